// File: rtl/regwrite_arbiter.sv
// Shares the single register-file write port between the write-back pipeline (A)
// and the multiply/divide unit (B); A has priority, B is guaranteed service within MAX_WAIT refusals.
module regwrite_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [4:0]  addr_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [4:0]  addr_b,
  input  logic [31:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        stall,
  output logic        mux_sel,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  typedef enum logic {
    A_PRI   = 1'b0,
    B_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic        stall_reg;
  logic        mux_sel_reg;
  logic        wr_en_reg;
  logic [4:0]  wr_addr_reg;
  logic [31:0] wr_data_reg;

  logic        xfer_a;
  logic        xfer_b;
  logic        b_refused;
  logic [4:0]  src_addr;
  logic [31:0] src_data;

  // Grants are combinational from state and requests, held low throughout reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (state_reg == A_PRI) begin
        gnt_a = req_a;
        gnt_b = req_b & ~req_a;
      end else begin
        gnt_b = req_b;
      end
    end
  end

  assign xfer_a    = req_a & gnt_a;
  assign xfer_b    = req_b & gnt_b;
  assign b_refused = req_b & ~gnt_b;

  // Source mux for the write port; transfers are mutually exclusive so xfer_b is the select.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_addr_mux
      assign src_addr[gi] = xfer_b ? addr_b[gi] : addr_a[gi];
    end
    for (gi = 0; gi < 32; gi++) begin : g_data_mux
      assign src_data[gi] = xfer_b ? data_b[gi] : data_a[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= A_PRI;
      wait_cnt_reg <= 4'd0;
      stall_reg    <= 1'b0;
    end else begin
      case (state_reg)
        A_PRI: begin
          if (xfer_b || !req_b) begin
            wait_cnt_reg <= 4'd0;
          end else if (b_refused) begin
            if (wait_cnt_reg == WAIT_LAST) begin
              state_reg    <= B_FORCE;
              stall_reg    <= 1'b1;
              wait_cnt_reg <= WAIT_SAT;
            end else if (wait_cnt_reg != WAIT_SAT) begin
              wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end
          end
        end
        B_FORCE: begin
          // Leave on the forced B transfer or if B withdrew its request.
          if (xfer_b || !req_b) begin
            state_reg    <= A_PRI;
            stall_reg    <= 1'b0;
            wait_cnt_reg <= 4'd0;
          end
        end
        default: begin
          state_reg    <= A_PRI;
          stall_reg    <= 1'b0;
          wait_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

  // Write port: address 0 is consumed but never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_sel_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 5'h00;
      wr_data_reg <= 32'h00000000;
    end else if (xfer_a || xfer_b) begin
      mux_sel_reg <= xfer_b;
      wr_en_reg   <= (src_addr != 5'h00);
      wr_addr_reg <= src_addr;
      wr_data_reg <= src_data;
    end else begin
      wr_en_reg <= 1'b0;
    end
  end

  assign stall   = stall_reg;
  assign mux_sel = mux_sel_reg;
  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: priority, starvation forcing, $zero writes, abort and reset.
module tb_regwrite_arbiter;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  logic        req_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        stall;
  logic        mux_sel;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int checks_cnt;
  int fail_cnt;

  regwrite_arbiter #(.MAX_WAIT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .req_b  (req_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .stall  (stall),
    .mux_sel(mux_sel),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst    = 1'b1;
    req_a  = 1'b1;
    addr_a = 5'h03;
    data_a = 32'h00000033;
    req_b  = 1'b1;
    addr_b = 5'h04;
    data_b = 32'h00000044;
    tick();
    tick();

    // Reset with both requests high.
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);

    rst = 1'b0;
    #1;
    chk("post_rst_gnt_a", 32'(gnt_a), 32'd1);
    chk("post_rst_gnt_b", 32'(gnt_b), 32'd0);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    chk("post_rst_wr_en", 32'(wr_en), 32'd1);
    chk("post_rst_wr_addr", 32'(wr_addr), 32'h03);
    chk("post_rst_wr_data", wr_data, 32'h00000033);
    tick();
    chk("post_rst_idle_wr_en", 32'(wr_en), 32'd0);

    // A only.
    req_a = 1'b1; addr_a = 5'h08; data_a = 32'h00000011;
    #1;
    chk("a_only_gnt_a", 32'(gnt_a), 32'd1);
    tick();
    req_a = 1'b0;
    chk("a_only_wr_en", 32'(wr_en), 32'd1);
    chk("a_only_wr_addr", 32'(wr_addr), 32'h08);
    chk("a_only_wr_data", wr_data, 32'h00000011);
    chk("a_only_mux_sel", 32'(mux_sel), 32'd0);
    tick();
    chk("a_only_after_wr_en", 32'(wr_en), 32'd0);

    // B only.
    req_b = 1'b1; addr_b = 5'h1F; data_b = 32'hF0000002;
    #1;
    chk("b_only_gnt_b", 32'(gnt_b), 32'd1);
    chk("b_only_gnt_a", 32'(gnt_a), 32'd0);
    tick();
    req_b = 1'b0;
    chk("b_only_wr_en", 32'(wr_en), 32'd1);
    chk("b_only_wr_addr", 32'(wr_addr), 32'h1F);
    chk("b_only_wr_data", wr_data, 32'hF0000002);
    chk("b_only_mux_sel", 32'(mux_sel), 32'd1);
    tick();

    // Starvation: B refused for cycles 0-3, forced on cycle 4.
    req_a = 1'b1; addr_a = 5'h05; data_a = 32'h000000A5;
    req_b = 1'b1; addr_b = 5'h09; data_b = 32'h000000B9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("starve_c%0d_gnt_b", i), 32'(gnt_b), 32'd0);
      chk($sformatf("starve_c%0d_stall", i), 32'(stall), 32'd0);
      tick();
    end
    chk("starve_c4_stall", 32'(stall), 32'd1);
    chk("starve_c4_gnt_a", 32'(gnt_a), 32'd0);
    chk("starve_c4_gnt_b", 32'(gnt_b), 32'd1);
    chk("starve_c4_wr_addr", 32'(wr_addr), 32'h05);
    tick();
    req_b = 1'b0;
    chk("starve_c5_wr_addr", 32'(wr_addr), 32'h09);
    chk("starve_c5_wr_data", wr_data, 32'h000000B9);
    chk("starve_c5_mux_sel", 32'(mux_sel), 32'd1);
    chk("starve_c5_wr_en", 32'(wr_en), 32'd1);
    chk("starve_c5_stall", 32'(stall), 32'd0);
    #1;
    chk("starve_c5_gnt_a", 32'(gnt_a), 32'd1);
    tick();
    req_a = 1'b0;
    chk("starve_c6_wr_addr", 32'(wr_addr), 32'h05);
    chk("starve_c6_mux_sel", 32'(mux_sel), 32'd0);
    tick();

    // $zero write: consumed, data updates, no write enable.
    req_a = 1'b1; addr_a = 5'h00; data_a = 32'hDEADBEEF;
    #1;
    chk("zero_gnt_a", 32'(gnt_a), 32'd1);
    tick();
    req_a = 1'b0;
    chk("zero_wr_en", 32'(wr_en), 32'd0);
    chk("zero_wr_data", wr_data, 32'hDEADBEEF);
    chk("zero_wr_addr", 32'(wr_addr), 32'h00);
    tick();

    // Withdrawal while in B_FORCE.
    req_a = 1'b1; addr_a = 5'h06; data_a = 32'h00000066;
    req_b = 1'b1; addr_b = 5'h07; data_b = 32'h00000077;
    repeat (4) tick();
    chk("abort_stall_in", 32'(stall), 32'd1);
    req_b = 1'b0;
    #1;
    chk("abort_gnt_a", 32'(gnt_a), 32'd0);
    chk("abort_gnt_b", 32'(gnt_b), 32'd0);
    tick();
    chk("abort_stall_out", 32'(stall), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_wr_addr_hold", 32'(wr_addr), 32'h06);
    chk("abort_gnt_a_resume", 32'(gnt_a), 32'd1);

    // Reset in the middle of B_FORCE, then the wait count restarts from zero.
    req_b = 1'b1;
    repeat (4) tick();
    chk("rst_mid_stall_in", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rst_mid_c%0d_stall", i), 32'(stall), 32'd0);
      tick();
    end
    chk("rst_mid_reforce_stall", 32'(stall), 32'd1);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
